// File: rtl/ram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_if
//
// Purpose: bundles the two buses of ram_stream_reader -- the RAM read port and
// the outgoing word stream -- so the reader and its environment connect with
// a single port each.
//
// Signals:
//   address  [WIDTHAD] reader -> RAM   read address
//   rden               reader -> RAM   read enable
//   q        [WIDTH]   RAM -> reader   read data, RD_LATENCY cycles after rden
//   st_data  [WIDTH]   reader -> sink  stream word (FIFO head)
//   st_valid           reader -> sink  st_data holds a word
//   st_ready           sink -> reader  sink accepts a word this cycle
//   st_last            reader -> sink  final word of the transfer
//
// Handshake: a word moves on every rising edge where st_valid and st_ready
// are both high. Once st_valid is raised, st_data/st_valid/st_last stay
// unchanged until that edge. st_valid never waits for st_ready, while
// st_ready may depend on st_valid. st_last only has meaning when st_valid=1.
//
// Modports: master = reader side, slave = RAM + sink side.
// ---------------------------------------------------------------------------
interface ram_stream_reader_if #(
  parameter int WIDTH   = 32,
  parameter int WIDTHAD = 10
);
  logic [WIDTHAD-1:0] address;
  logic               rden;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   st_data;
  logic               st_valid;
  logic               st_ready;
  logic               st_last;

  modport master (
    output address, rden, st_data, st_valid, st_last,
    input  q, st_ready
  );

  modport slave (
    input  address, rden, st_data, st_valid, st_last,
    output q, st_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//
// Purpose: reads `length` consecutive words from a RAM, starting at
// `base_addr` and wrapping at the end of the address space. It sends them
// out on a valid/ready stream and marks the final word with st_last.
// Read data land in a small FIFO. Reads are only issued when the FIFO has
// room for them, so sink back-pressure throttles the RAM reads and no data
// is lost.
//
// Parameters:
//   WIDTH       data word width
//   WIDTHAD     RAM address width (2**WIDTHAD words)
//   RD_LATENCY  1 = unregistered RAM output, 2 = registered RAM output
//   FIFO_DEPTH  output buffer depth in words, >= RD_LATENCY+2
//
// Ports:
//   clock, sclr       clock, synchronous active-high reset
//   start             one-cycle request, sampled only in IDLE
//   base_addr, length first address / word count (0..2**WIDTHAD), taken with start
//   busy              high in RUN and DRAIN
//   done              one-cycle pulse (DONE state)
//   dbg_state         current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   bus               RAM read port + output stream (master side)
// ---------------------------------------------------------------------------
module ram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int WIDTHAD    = 10,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                sclr,
  input  logic                start,
  input  logic [WIDTHAD-1:0]  base_addr,
  input  logic [WIDTHAD:0]    length,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state,
  ram_stream_reader_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  // Wide enough for (reads in flight + words buffered), at most FIFO_DEPTH + RD_LATENCY.
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam logic [WIDTHAD:0] LEN_ONE = {{WIDTHAD{1'b0}}, 1'b1};

  // Elaboration-time parameter checks.
  if ((RD_LATENCY != 1) && (RD_LATENCY != 2)) begin : g_bad_latency
    $error("ram_stream_reader: RD_LATENCY must be 1 or 2");
  end
  if (FIFO_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
    $error("ram_stream_reader: FIFO_DEPTH must be >= RD_LATENCY+2");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [WIDTHAD-1:0]    addr_q, addr_d;          // next read address
  logic [WIDTHAD:0]      len_q, len_d;            // words in this transfer
  logic [WIDTHAD:0]      issue_rem_q, issue_rem_d; // reads still to issue
  logic [WIDTHAD:0]      beat_cnt_q, beat_cnt_d;  // words already handed to the sink
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;          // rden delayed to the q-valid cycle

  logic [WIDTH-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // ---------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------
  logic [OCC_W-1:0] inflight;
  logic             credit_ok;
  logic             rden;
  logic             push;
  logic             pop;
  logic             st_valid;
  logic             st_last;
  logic [WIDTHAD:0] last_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + OCC_W'(pipe_q[i]);
    end
    // A new read is only issued if it is guaranteed a FIFO slot when its
    // data arrives, even if the sink stalls from now on. A pop in the
    // same cycle does not give credit back early, which keeps this check
    // free of any path from st_ready.
    credit_ok = (inflight + OCC_W'(count_q)) < OCC_W'(FIFO_DEPTH);
    rden      = (state_q == S_RUN) && credit_ok;
    push      = pipe_q[RD_LATENCY-1];
    st_valid  = (count_q != '0);
    pop       = st_valid && bus.st_ready;
    last_idx  = len_q - LEN_ONE;
    st_last   = st_valid && (beat_cnt_q == last_idx);
  end

  // ---------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_rem_d = issue_rem_q;
    beat_cnt_d  = beat_cnt_q;
    pipe_d      = pipe_q << 1;
    pipe_d[0]   = rden;
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Address wraps naturally at 2**WIDTHAD.
    if (rden) begin
      addr_d      = addr_q + WIDTHAD'(1);
      issue_rem_d = issue_rem_q - LEN_ONE;
    end
    if (pop) begin
      beat_cnt_d = beat_cnt_q + LEN_ONE;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          len_d       = length;
          issue_rem_d = length;
          beat_cnt_d  = '0;
          state_d     = (length == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (rden && (issue_rem_q == LEN_ONE)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && st_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_rem_q <= '0;
      beat_cnt_q  <= '0;
      pipe_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_rem_q <= issue_rem_d;
      beat_cnt_q  <= beat_cnt_d;
      pipe_q      <= pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clock) begin
    if (push && !sclr) begin
      fifo_mem_q[wr_ptr_q] <= bus.q;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.address  = addr_q;
  assign bus.rden     = rden;
  assign bus.st_data  = fifo_mem_q[rd_ptr_q];
  assign bus.st_valid = st_valid;
  assign bus.st_last  = st_last;

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

  // The credit check must make this impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (sclr)
    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule
